// File: rtl/wbc_bus_arbiter.sv
// Wishbone classic shared-bus interconnect: round-robin grant of NM masters,
// top-address-bit decode onto NS slaves, error reply for unmapped or stalled accesses.
module wbc_bus_arbiter #(
  parameter int  NM        = 2,
  parameter int  ADDRWIDTH = 32,
  parameter int  DATAWIDTH = 32,
  parameter int  MUXWIDTH  = 3,
  parameter      SLAVE_MUX = {3'b001, 3'b000},
  parameter int  TIMEOUT   = 255,
  localparam int SELWIDTH  = DATAWIDTH / 8,
  localparam int NS        = $bits(SLAVE_MUX) / MUXWIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NM-1:0]             m_cyc_i,
  input  logic [NM-1:0]             m_stb_i,
  input  logic [NM-1:0]             m_we_i,
  input  logic [NM*ADDRWIDTH-1:0]   m_adr_i,
  input  logic [NM*DATAWIDTH-1:0]   m_dat_i,
  input  logic [NM*SELWIDTH-1:0]    m_sel_i,
  output logic [NM-1:0]             m_ack_o,
  output logic [NM-1:0]             m_err_o,
  output logic [DATAWIDTH-1:0]      m_dat_o,
  output logic [NS-1:0]             s_cyc_o,
  output logic [NS-1:0]             s_stb_o,
  output logic                      s_we_o,
  output logic [ADDRWIDTH-1:0]      s_adr_o,
  output logic [DATAWIDTH-1:0]      s_dat_o,
  output logic [SELWIDTH-1:0]       s_sel_o,
  input  logic [NS-1:0]             s_ack_i,
  input  logic [NS-1:0]             s_err_i,
  input  logic [NS*DATAWIDTH-1:0]   s_dat_i,
  output logic [NM-1:0]             grant_o
);

  localparam int          IW       = (NM > 1) ? $clog2(NM) : 1;
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  last_q, last_d;
  logic [15:0]    tcnt_q, tcnt_d;

  int unsigned    gidx, sidx, rr_idx;
  logic           busy, g_cyc, g_stb, mapped, found;
  logic           sl_ack, sl_err, unmapped_err, timeout_err;
  logic [ADDRWIDTH-1:0] g_adr;

  assign busy  = (state_q == BUSY);
  assign gidx  = 32'(last_q);
  assign g_cyc = m_cyc_i[gidx];
  assign g_stb = m_stb_i[gidx];
  assign g_adr = m_adr_i[gidx*ADDRWIDTH +: ADDRWIDTH];

  // Later matches override earlier ones, so the highest matching slave index wins.
  always_comb begin
    mapped = 1'b0;
    sidx   = 0;
    for (int unsigned k = 0; k < NS; k++) begin
      if (g_adr[ADDRWIDTH-1 -: MUXWIDTH] == SLAVE_MUX[k*MUXWIDTH +: MUXWIDTH]) begin
        mapped = 1'b1;
        sidx   = k;
      end
    end
  end

  assign sl_ack       = mapped & s_ack_i[sidx];
  assign sl_err       = mapped & s_err_i[sidx];
  assign unmapped_err = busy & g_stb & ~mapped;
  assign timeout_err  = busy & g_stb & mapped & (tcnt_q == TO_LIMIT);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    tcnt_d  = '0;
    found   = 1'b0;
    rr_idx  = 0;
    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          state_d = BUSY;
          for (int unsigned i = 1; i <= NM; i++) begin
            rr_idx = (gidx + i) % NM;
            if (!found && m_cyc_i[rr_idx]) begin
              found  = 1'b1;
              last_d = IW'(rr_idx);
            end
          end
        end
      end
      BUSY: begin
        if (g_stb && mapped && !sl_ack && !sl_err && !timeout_err)
          tcnt_d = tcnt_q + 16'd1;
        if (!g_cyc)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_dat_o = '0;
    s_cyc_o = '0;
    s_stb_o = '0;
    s_we_o  = m_we_i[gidx];
    s_adr_o = g_adr;
    s_dat_o = m_dat_i[gidx*DATAWIDTH +: DATAWIDTH];
    s_sel_o = m_sel_i[gidx*SELWIDTH +: SELWIDTH];
    if (busy) begin
      grant_o[gidx] = 1'b1;
      m_ack_o[gidx] = sl_ack;
      m_err_o[gidx] = sl_err | timeout_err | unmapped_err;
      if (mapped) begin
        // The timed-out strobe is withheld from the slave for the error cycle.
        s_cyc_o[sidx] = g_cyc;
        s_stb_o[sidx] = g_stb & ~timeout_err;
        m_dat_o       = s_dat_i[sidx*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= IW'(NM - 1);
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_wbc_bus_arbiter.sv
// Randomised scoreboard bench for wbc_bus_arbiter: transaction-level round-robin
// model predicts grants and per-transfer responses; a negedge monitor checks them.
module tb_wbc_bus_arbiter;
  localparam int NM = 2, NS = 2, AW = 32, DW = 32, SW = 4, TO = 4, MAXX = 8;

  logic clk = 1'b0;
  logic reset;
  logic [NM-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*DW-1:0] m_dat_i;
  logic [NM*SW-1:0] m_sel_i;
  logic [NM-1:0]    m_ack_o, m_err_o, grant_o;
  logic [DW-1:0]    m_dat_o;
  logic [NS-1:0]    s_cyc_o, s_stb_o, s_ack_i, s_err_i;
  logic             s_we_o;
  logic [AW-1:0]    s_adr_o;
  logic [DW-1:0]    s_dat_o;
  logic [SW-1:0]    s_sel_o;
  logic [NS*DW-1:0] s_dat_i;

  wbc_bus_arbiter #(.NM(NM), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i),
    .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_dat_o(m_dat_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .s_dat_i(s_dat_i), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave models: mode 0/1 ack, 2 err, 3 never respond; reply after slat wait cycles.
  int unsigned   smode[NS], slat[NS], swait[NS];
  logic [DW-1:0] sdat[NS];
  logic [2:0]    smatch[NS] = '{3'b000, 3'b001};

  always_comb begin
    s_ack_i = '0;
    s_err_i = '0;
    s_dat_i = '0;
    for (int k = 0; k < NS; k++) begin
      s_ack_i[k] = s_stb_o[k] && smode[k] < 2 && swait[k] == slat[k];
      s_err_i[k] = s_stb_o[k] && smode[k] == 2 && swait[k] == slat[k];
      s_dat_i[k*DW +: DW] = sdat[k];
    end
  end

  always @(posedge clk)
    for (int k = 0; k < NS; k++)
      swait[k] <= (s_stb_o[k] && !s_ack_i[k] && !s_err_i[k]) ? swait[k] + 1 : 0;

  // Per-master transfer lists; xlast marks the final transfer of a bus cycle.
  logic [AW-1:0] xadr[NM][MAXX];
  logic [DW-1:0] xdat[NM][MAXX];
  logic [SW-1:0] xsel[NM][MAXX];
  logic          xwe[NM][MAXX];
  bit            xlast[NM][MAXX];
  int unsigned   nx[NM];

  typedef struct {
    int unsigned   m;
    bit            err;
    logic [DW-1:0] rdat;
    logic [AW-1:0] adr;
    logic          we;
    logic [DW-1:0] wdat;
    logic [SW-1:0] sel;
    int unsigned   lat;
    logic [NS-1:0] stb;
    logic [NS-1:0] cyc;
  } exp_t;

  exp_t        sq[$];
  int unsigned gq[$];
  int unsigned ptr;
  bit          mon_en = 0;

  function automatic exp_t predict(int unsigned j, int unsigned t);
    exp_t e;
    int   k;
    logic [2:0] top;
    e = '{default: 0};
    e.m = j; e.adr = xadr[j][t]; e.we = xwe[j][t]; e.wdat = xdat[j][t]; e.sel = xsel[j][t];
    top = e.adr[AW-1 -: 3];
    k = -1;
    for (int s = 0; s < NS; s++) if (top == smatch[s]) k = s;
    if (k < 0) begin
      e.err = 1; e.lat = 0; e.stb = '0; e.cyc = '0;
    end else begin
      e.cyc = '0; e.cyc[k] = 1'b1;
      if (smode[k] < 2) begin
        e.err = 0; e.lat = slat[k]; e.stb = e.cyc; e.rdat = sdat[k];
      end else if (smode[k] == 2) begin
        e.err = 1; e.lat = slat[k]; e.stb = e.cyc;
      end else begin
        e.err = 1; e.lat = TO; e.stb = '0;
      end
    end
    return e;
  endfunction

  task automatic build_expect();
    int unsigned bleft[NM], pos[NM];
    bit          picked, last;
    int unsigned j;
    for (int m = 0; m < NM; m++) begin
      bleft[m] = 0; pos[m] = 0;
      for (int t = 0; t < int'(nx[m]); t++) if (xlast[m][t]) bleft[m]++;
    end
    do begin
      picked = 0;
      j = 0;
      for (int unsigned i = 1; i <= NM && !picked; i++) begin
        j = (ptr + i) % NM;
        if (bleft[j] > 0) picked = 1;
      end
      if (picked) begin
        ptr = j;
        gq.push_back(j);
        do begin
          sq.push_back(predict(j, pos[j]));
          last = xlast[j][pos[j]];
          pos[j]++;
        end while (!last);
        bleft[j]--;
      end
    end while (picked);
  endtask

  task automatic add_x(input int unsigned j, input logic [AW-1:0] a, input bit last);
    xadr[j][nx[j]]  = a;
    xwe[j][nx[j]]   = 1'($urandom_range(0, 1));
    xdat[j][nx[j]]  = $urandom;
    xsel[j][nx[j]]  = 4'($urandom_range(1, 15));
    xlast[j][nx[j]] = last;
    nx[j]++;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int unsigned r;
    logic [2:0]  top;
    r   = $urandom_range(0, 2);
    top = (r < 2) ? 3'(r) : 3'($urandom_range(2, 7));
    return {top, 29'($urandom)};
  endfunction

  task automatic gen_random();
    int unsigned mask, nb, nt;
    mask = $urandom_range(1, 3);
    for (int k = 0; k < NS; k++) begin
      smode[k] = $urandom_range(0, 3);
      slat[k]  = $urandom_range(0, 2);
      sdat[k]  = $urandom;
    end
    for (int unsigned j = 0; j < NM; j++) begin
      nx[j] = 0;
      if (mask[j]) begin
        nb = $urandom_range(1, 2);
        for (int unsigned b = 0; b < nb; b++) begin
          nt = $urandom_range(1, 3);
          for (int unsigned t = 0; t < nt; t++) add_x(j, rand_addr(), t == nt - 1);
        end
      end
    end
  endtask

  task automatic gen_directed();
    smode[0] = 0; slat[0] = 1; sdat[0] = 32'h0123_4567;
    smode[1] = 3; slat[1] = 0; sdat[1] = 32'h89AB_CDEF;
    nx[0] = 0; nx[1] = 0;
    add_x(0, 32'h0000_0010, 0);
    add_x(0, 32'h2000_0020, 0);
    add_x(0, 32'h2000_0024, 0);
    add_x(0, 32'hE000_0000, 1);
    add_x(0, 32'h0000_0040, 1);
    add_x(1, 32'h0000_0080, 1);
    add_x(1, 32'h0000_00C0, 1);
  endtask

  bit          active[NM], gap[NM];
  int unsigned cur[NM];

  task automatic drive_x(input int unsigned j);
    m_cyc_i[j] = 1'b1;
    m_stb_i[j] = 1'b1;
    m_we_i[j]  = xwe[j][cur[j]];
    m_adr_i[j*AW +: AW] = xadr[j][cur[j]];
    m_dat_i[j*DW +: DW] = xdat[j][cur[j]];
    m_sel_i[j*SW +: SW] = xsel[j][cur[j]];
  endtask

  task automatic idle_x(input int unsigned j);
    m_cyc_i[j] = 1'b0;
    m_stb_i[j] = 1'b0;
  endtask

  function automatic bit any_active();
    bit a = 0;
    for (int j = 0; j < NM; j++) a |= active[j];
    return a;
  endfunction

  task automatic run_episode();
    logic [NM-1:0] resp;
    build_expect();
    @(posedge clk); #1;
    for (int unsigned j = 0; j < NM; j++) begin
      active[j] = nx[j] > 0; cur[j] = 0; gap[j] = 0;
      if (active[j]) drive_x(j);
    end
    for (int c = 0; c < 400 && any_active(); c++) begin
      @(negedge clk);
      resp = m_ack_o | m_err_o;
      @(posedge clk); #1;
      for (int unsigned j = 0; j < NM; j++) begin
        if (active[j]) begin
          if (gap[j]) begin
            gap[j] = 0;
            drive_x(j);
          end else if (resp[j]) begin
            if (xlast[j][cur[j]]) begin
              cur[j]++;
              if (cur[j] == nx[j]) active[j] = 0; else gap[j] = 1;
              idle_x(j);
            end else begin
              cur[j]++;
              drive_x(j);
            end
          end
        end
      end
    end
    chk("episode_budget", 64'(any_active()), 0);
    for (int unsigned j = 0; j < NM; j++) begin active[j] = 0; idle_x(j); end
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sb_drain", 64'(sq.size()), 0);
    chk("grant_drain", 64'(gq.size()), 0);
    sq.delete();
    gq.delete();
  endtask

  // Monitor: grants on each 0 -> nonzero transition, responses whenever any ack/err shows.
  initial begin
    logic [NM-1:0] prev_grant, exp_mask, one_g, resp;
    int unsigned   wait_n, g;
    exp_t          e;
    prev_grant = '0;
    wait_n     = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_grant = grant_o;
        wait_n     = 0;
      end else begin
        if (grant_o != '0 && prev_grant == '0) begin
          if (gq.size() == 0) chk("grant_unexpected", 64'(grant_o), 0);
          else begin
            g = gq.pop_front();
            one_g = '0; one_g[g] = 1'b1;
            chk("grant", 64'(grant_o), 64'(one_g));
          end
        end else if (grant_o != '0 && prev_grant != '0 && grant_o != prev_grant) begin
          chk("grant_no_idle_gap", 64'(grant_o), 64'(prev_grant));
        end
        prev_grant = grant_o;
        resp = m_ack_o | m_err_o;
        if (resp != '0) begin
          if (sq.size() == 0) chk("unexpected_resp", 64'(resp), 0);
          else begin
            e = sq.pop_front();
            exp_mask = '0; exp_mask[e.m] = 1'b1;
            chk("m_ack", 64'(m_ack_o), e.err ? 64'(0) : 64'(exp_mask));
            chk("m_err", 64'(m_err_o), e.err ? 64'(exp_mask) : 64'(0));
            chk("latency", 64'(wait_n), 64'(e.lat));
            chk("s_stb", 64'(s_stb_o), 64'(e.stb));
            chk("s_cyc", 64'(s_cyc_o), 64'(e.cyc));
            chk("s_adr", 64'(s_adr_o), 64'(e.adr));
            chk("s_we", 64'(s_we_o), 64'(e.we));
            chk("s_dat", 64'(s_dat_o), 64'(e.wdat));
            chk("s_sel", 64'(s_sel_o), 64'(e.sel));
            if (!e.err) chk("m_dat", 64'(m_dat_o), 64'(e.rdat));
          end
          wait_n = 0;
        end else if (grant_o != '0 && (m_stb_i & grant_o) != '0) begin
          wait_n++;
        end else begin
          wait_n = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    for (int k = 0; k < NS; k++) begin smode[k] = 0; slat[k] = 0; sdat[k] = '0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 64'(grant_o), 0);
    chk("rst_s_cyc", 64'(s_cyc_o), 0);
    chk("rst_s_stb", 64'(s_stb_o), 0);
    chk("rst_m_ack", 64'(m_ack_o), 0);
    chk("rst_m_err", 64'(m_err_o), 0);
    chk("rst_m_dat", 64'(m_dat_o), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single read to slave 1 answered with zero wait.
    smode[1] = 0; slat[1] = 0; sdat[1] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_we_i[0] = 1'b0;
    m_adr_i[0 +: AW] = 32'h2000_0000;
    @(negedge clk);
    chk("arb_idle_grant", 64'(grant_o), 0);
    chk("arb_idle_stb", 64'(s_stb_o), 0);
    @(negedge clk);
    chk("d1_grant", 64'(grant_o), 64'h1);
    chk("d1_s_stb", 64'(s_stb_o), 64'h2);
    chk("d1_m_ack", 64'(m_ack_o), 64'h1);
    chk("d1_m_dat", 64'(m_dat_o), 64'hDEAD_BEEF);
    @(posedge clk); #1;
    idle_x(0);
    repeat (3) @(posedge clk);

    // Reset in the middle of a stalled wait.
    smode[1] = 3;
    @(posedge clk); #1;
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_grant", 64'(grant_o), 64'h1);
    chk("mid_no_err", 64'(m_err_o), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_grant", 64'(grant_o), 0);
    chk("rst_mid_s_cyc", 64'(s_cyc_o), 0);
    chk("rst_mid_s_stb", 64'(s_stb_o), 0);
    chk("rst_mid_m_err", 64'(m_err_o), 0);
    @(posedge clk); #1;
    idle_x(0);
    reset = 1'b0;
    ptr = NM - 1;
    repeat (2) @(posedge clk);

    mon_en = 1;
    gen_directed();
    run_episode();
    for (int n = 0; n < 40; n++) begin
      gen_random();
      run_episode();
    end
    mon_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
